// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side bundle for the branch sequencing controller: ID lookup, EX resolution,
// redirect/flush outputs and branch statistics. The pipeline drives through master; the controller uses slave.
interface branch_predict_ctrl_if;
  logic        stall;
  logic        id_valid;
  logic [2:0]  id_br_ctrl;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        pred_taken;
  logic        ex_valid;
  logic [2:0]  ex_br_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        ex_br_true;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output stall, id_valid, id_br_ctrl, id_pc, id_target,
    output ex_valid, ex_br_ctrl, ex_pc, ex_target, ex_pred_taken, ex_br_true,
    input  pred_taken, redirect, redirect_pc, flush_ifid, flush_idex,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  stall, id_valid, id_br_ctrl, id_pc, id_target,
    input  ex_valid, ex_br_ctrl, ex_pc, ex_target, ex_pred_taken, ex_br_true,
    output pred_taken, redirect, redirect_pc, flush_ifid, flush_idex,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Branch sequencing controller: 2-bit-counter BHT prediction in ID, misprediction recovery from EX.
// Optional resolved-branch / misprediction counters are built when BRANCH_STATS_EN is defined.
module branch_predict_ctrl #(
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_ctrl_if.slave bus
);

  localparam int BHT_DEPTH = 1 << BHT_IDX_W;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_STRONG_NT = 2'b00;
  localparam ctr_t CTR_WEAK_NT   = 2'b01;
  localparam ctr_t CTR_STRONG_T  = 2'b11;

  ctr_t bht [BHT_DEPTH];

  logic [BHT_IDX_W-1:0] id_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 id_is_br;
  logic                 ex_is_br;
  logic                 resolve;
  logic                 mispredict;
  logic                 pred_taken;
  ctr_t                 ctr_next;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic        flush_idex;

  // Codes 5..7 decode the same as code 0: not a branch.
  function automatic logic is_branch(input logic valid, input logic [2:0] code);
    return valid & (code inside {[3'd1:3'd4]});
  endfunction

  assign id_idx   = bus.id_pc[BHT_IDX_W+1:2];
  assign ex_idx   = bus.ex_pc[BHT_IDX_W+1:2];
  assign id_is_br = is_branch(bus.id_valid, bus.id_br_ctrl);
  assign ex_is_br = is_branch(bus.ex_valid, bus.ex_br_ctrl);

  // Folding ~rst and ~stall in here gives the freeze/reset case top priority for free.
  assign pred_taken = id_is_br & ~bus.stall & ~rst & bht[id_idx][1];
  assign resolve    = ex_is_br & ~bus.stall & ~rst;
  assign mispredict = resolve & (bus.ex_br_true != bus.ex_pred_taken);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (mispredict) begin
      redirect    = 1'b1;
      redirect_pc = bus.ex_br_true ? bus.ex_target : bus.ex_pc + 32'd4;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end else if (pred_taken) begin
      redirect    = 1'b1;
      redirect_pc = bus.id_target;
      flush_ifid  = 1'b1;
    end
  end

  always_comb begin
    ctr_next = bht[ex_idx];
    if (bus.ex_br_true) begin
      if (bht[ex_idx] != CTR_STRONG_T) ctr_next = bht[ex_idx] + 2'd1;
    end else begin
      if (bht[ex_idx] != CTR_STRONG_NT) ctr_next = bht[ex_idx] - 2'd1;
    end
  end

  // NOTE: the BHT is a small flop array, so it is reset entry by entry; a RAM-based table could not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        bht[i] <= CTR_WEAK_NT;
      end
    end else if (resolve) begin
      bht[ex_idx] <= ctr_next;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else if (resolve) begin
      if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`else
  assign bus.stat_branches    = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

  assign bus.pred_taken  = pred_taken;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios followed by randomized traffic
// compared against a counter-array model of the predictor.
module tb_branch_predict_ctrl;

`ifdef BRANCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif
  localparam int ENTRIES = 16;

  typedef struct packed {
    logic        pred;
    logic        redirect;
    logic        fi;
    logic        fe;
    logic [31:0] pc;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Model: one saturating counter (0..3) per entry; taken-prediction when counter >= 2.
  int unsigned     mdl_ctr [ENTRIES];
  longint unsigned mdl_br;
  longint unsigned mdl_mis;

  branch_predict_ctrl_if bus ();

  branch_predict_ctrl #(.BHT_IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % ENTRIES);
  endfunction

  function automatic bit is_br(input logic valid, input logic [2:0] code);
    return valid && code >= 3'd1 && code <= 3'd4;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    bit   mis;
    e = '0;
    e.pred = is_br(bus.id_valid, bus.id_br_ctrl) && !bus.stall && !rst
             && mdl_ctr[idx_of(bus.id_pc)] >= 2;
    mis = is_br(bus.ex_valid, bus.ex_br_ctrl) && !bus.stall && !rst
          && (bus.ex_br_true != bus.ex_pred_taken);
    if (mis) begin
      e.redirect = 1'b1;
      e.fi       = 1'b1;
      e.fe       = 1'b1;
      e.pc       = bus.ex_br_true ? bus.ex_target : bus.ex_pc + 32'd4;
    end else if (e.pred) begin
      e.redirect = 1'b1;
      e.fi       = 1'b1;
      e.pc       = bus.id_target;
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_stat_br();
    return STATS_EN ? 32'(mdl_br) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_stat_mis();
    return STATS_EN ? 32'(mdl_mis) : 32'd0;
  endfunction

  // Apply the clock edge to the model using the inputs currently driven, then move to the next falling edge.
  task automatic advance();
    int i;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) mdl_ctr[k] = 1;
      mdl_br  = 0;
      mdl_mis = 0;
    end else if (!bus.stall && is_br(bus.ex_valid, bus.ex_br_ctrl)) begin
      i = idx_of(bus.ex_pc);
      if (bus.ex_br_true) mdl_ctr[i] = (mdl_ctr[i] == 3) ? 3 : mdl_ctr[i] + 1;
      else                mdl_ctr[i] = (mdl_ctr[i] == 0) ? 0 : mdl_ctr[i] - 1;
      if (mdl_br < 64'hFFFF_FFFF) mdl_br++;
      if (bus.ex_br_true != bus.ex_pred_taken && mdl_mis < 64'hFFFF_FFFF) mdl_mis++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.id_valid      = 1'b0;
    bus.id_br_ctrl    = 3'd0;
    bus.id_pc         = 32'd0;
    bus.id_target     = 32'd0;
    bus.ex_valid      = 1'b0;
    bus.ex_br_ctrl    = 3'd0;
    bus.ex_pc         = 32'd0;
    bus.ex_target     = 32'd0;
    bus.ex_pred_taken = 1'b0;
    bus.ex_br_true    = 1'b0;
  endtask

  task automatic set_id(input logic [2:0] code, input logic [31:0] pc, input logic [31:0] tgt);
    bus.id_valid   = 1'b1;
    bus.id_br_ctrl = code;
    bus.id_pc      = pc;
    bus.id_target  = tgt;
  endtask

  task automatic set_ex(input logic [2:0] code, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic taken, input logic predicted);
    bus.ex_valid      = 1'b1;
    bus.ex_br_ctrl    = code;
    bus.ex_pc         = pc;
    bus.ex_target     = tgt;
    bus.ex_br_true    = taken;
    bus.ex_pred_taken = predicted;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      idle();
      set_id(3'd1, 32'h40, 32'h300);
      set_ex(3'd2, 32'h80, 32'h90, 1'b1, 1'b0);
      #1;
      checks++;
      if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags cycle %0d got %b want 0000", c,
                 {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex});
      end
      checks++;
      if (bus.redirect_pc !== 32'd0) begin
        errors++;
        $display("FAIL reset_pc cycle %0d got %h want 0", c, bus.redirect_pc);
      end
      if (c == 1) begin
        checks++;
        if ({bus.stat_branches, bus.stat_mispredicts} !== 64'd0) begin
          errors++;
          $display("FAIL reset_stats got %h/%h want 0/0", bus.stat_branches, bus.stat_mispredicts);
        end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_predict();
    // Fresh counter (weak-NT) must not predict.
    idle(); set_id(3'd1, 32'h40, 32'h300); #1;
    checks++;
    if ({bus.pred_taken, bus.redirect} !== 2'b00) begin
      errors++; $display("FAIL cold_lookup got %b want 00", {bus.pred_taken, bus.redirect});
    end
    advance();
    // Taken branch predicted not-taken: recover to target.
    idle(); set_ex(3'd1, 32'h40, 32'h80, 1'b1, 1'b0); #1;
    checks++;
    if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== 4'b0111
        || bus.redirect_pc !== 32'h80) begin
      errors++; $display("FAIL mp_taken got %b pc %h want 0111 pc 00000080",
        {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
    end
    advance();
    // Update visible the very next cycle: weak-T predicts taken.
    idle(); set_id(3'd1, 32'h40, 32'h300); #1;
    checks++;
    if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== 4'b1110
        || bus.redirect_pc !== 32'h300) begin
      errors++; $display("FAIL pred_taken got %b pc %h want 1110 pc 00000300",
        {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      idle(); set_ex(3'd1, 32'h40, 32'h80, 1'b1, 1'b1); #1;
      checks++;
      if (bus.redirect !== 1'b0) begin
        errors++; $display("FAIL correct_taken_%0d redirect got %b want 0", k, bus.redirect);
      end
      advance();
    end
    // Saturated strong-T, one not-taken: fall-through recovery and still predicts taken.
    idle(); set_ex(3'd1, 32'h40, 32'h80, 1'b0, 1'b1); #1;
    checks++;
    if ({bus.redirect, bus.flush_ifid, bus.flush_idex} !== 3'b111 || bus.redirect_pc !== 32'h44) begin
      errors++; $display("FAIL mp_not_taken got %b pc %h want 111 pc 00000044",
        {bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
    end
    advance();
    idle(); set_id(3'd2, 32'h40, 32'h340); #1;
    checks++;
    if (bus.pred_taken !== 1'b1 || bus.redirect_pc !== 32'h340) begin
      errors++; $display("FAIL sat_then_nt got pred %b pc %h want 1 pc 00000340",
        bus.pred_taken, bus.redirect_pc);
    end
    advance();
  endtask

  task automatic test_simultaneous();
    idle();
    set_id(3'd1, 32'h40, 32'h200);
    set_ex(3'd3, 32'h100, 32'h180, 1'b0, 1'b1);
    #1;
    checks++;
    if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== 4'b1111
        || bus.redirect_pc !== 32'h104) begin
      errors++; $display("FAIL ex_wins got %b pc %h want 1111 pc 00000104",
        {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
    end
    advance();
  endtask

  task automatic test_stall();
    longint unsigned mis_before;
    mis_before = mdl_mis;
    for (int c = 0; c < 3; c++) begin
      idle(); bus.stall = 1'b1;
      set_id(3'd1, 32'h8, 32'h600);
      set_ex(3'd4, 32'h8, 32'h500, 1'b1, 1'b0);
      #1;
      checks++;
      if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== 4'b0000
          || bus.redirect_pc !== 32'd0) begin
        errors++; $display("FAIL stall_%0d got %b pc %h want 0000 pc 0", c,
          {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
      end
      advance();
    end
    bus.stall = 1'b0; #1;
    checks++;
    if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== 4'b0111
        || bus.redirect_pc !== 32'h500) begin
      errors++; $display("FAIL stall_release got %b pc %h want 0111 pc 00000500",
        {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
    end
    advance();
    idle(); #1;
    checks++;
    if (bus.redirect !== 1'b0) begin
      errors++; $display("FAIL stall_once redirect got %b want 0", bus.redirect);
    end
    checks++;
    if (bus.stat_mispredicts !== (STATS_EN ? 32'(mis_before + 1) : 32'd0)) begin
      errors++; $display("FAIL stall_stat got %0d want %0d", bus.stat_mispredicts,
        STATS_EN ? 32'(mis_before + 1) : 32'd0);
    end
    advance();
    // One update during release leaves weak-T; a not-taken brings it back to weak-NT.
    idle(); set_ex(3'd4, 32'h8, 32'h500, 1'b0, 1'b1); #1;
    advance();
    idle(); set_id(3'd1, 32'h8, 32'h600); #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL stall_no_bht_update pred got %b want 0", bus.pred_taken);
    end
    advance();
  endtask

  task automatic test_nonbranch();
    logic [31:0] br_before;
    logic [31:0] mis_before;
    br_before  = exp_stat_br();
    mis_before = exp_stat_mis();
    for (int c = 5; c <= 7; c++) begin
      idle();
      set_id(3'(c), 32'hC, 32'h700);
      set_ex(3'(c), 32'hC, 32'h800, 1'b1, 1'b0);
      #1;
      checks++;
      if ({bus.pred_taken, bus.redirect} !== 2'b00) begin
        errors++; $display("FAIL code%0d got %b want 00", c, {bus.pred_taken, bus.redirect});
      end
      advance();
    end
    bus.ex_valid = 1'b0; #1;
    checks++;
    if (bus.stat_branches !== br_before || bus.stat_mispredicts !== mis_before) begin
      errors++; $display("FAIL nonbranch_stats got %0d/%0d want %0d/%0d",
        bus.stat_branches, bus.stat_mispredicts, br_before, mis_before);
    end
    idle(); set_id(3'd1, 32'hC, 32'h700); #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++; $display("FAIL nonbranch_bht pred got %b want 0", bus.pred_taken);
    end
    advance();
  endtask

  task automatic test_wrap();
    idle(); set_ex(3'd1, 32'hFFFF_FFFC, 32'h1000, 1'b0, 1'b1); #1;
    checks++;
    if ({bus.redirect, bus.flush_ifid, bus.flush_idex} !== 3'b111 || bus.redirect_pc !== 32'd0) begin
      errors++; $display("FAIL pc_wrap got %b pc %h want 111 pc 00000000",
        {bus.redirect, bus.flush_ifid, bus.flush_idex}, bus.redirect_pc);
    end
    advance();
  endtask

  task automatic test_random();
    exp_t e;
    for (int n = 0; n < 600; n++) begin
      idle();
      rst               = ($urandom_range(0, 99) < 2);
      bus.stall         = ($urandom_range(0, 99) < 15);
      bus.id_valid      = ($urandom_range(0, 99) < 80);
      bus.id_br_ctrl    = 3'($urandom_range(0, 7));
      bus.id_pc         = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 15) * 4);
      bus.id_target     = $urandom;
      bus.ex_valid      = ($urandom_range(0, 99) < 80);
      bus.ex_br_ctrl    = 3'($urandom_range(0, 7));
      bus.ex_pc         = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                          : (($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 15) * 4));
      bus.ex_target     = $urandom;
      bus.ex_br_true    = 1'($urandom_range(0, 1));
      bus.ex_pred_taken = 1'($urandom_range(0, 1));
      #1;
      e = model_expect();
      checks++;
      if ({bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex} !== {e.pred, e.redirect, e.fi, e.fe}) begin
        errors++; $display("FAIL rand_flags n=%0d got %b want %b", n,
          {bus.pred_taken, bus.redirect, bus.flush_ifid, bus.flush_idex}, {e.pred, e.redirect, e.fi, e.fe});
      end
      checks++;
      if (bus.redirect_pc !== e.pc) begin
        errors++; $display("FAIL rand_pc n=%0d got %h want %h", n, bus.redirect_pc, e.pc);
      end
      checks++;
      if (bus.stat_branches !== exp_stat_br() || bus.stat_mispredicts !== exp_stat_mis()) begin
        errors++; $display("FAIL rand_stats n=%0d got %0d/%0d want %0d/%0d", n,
          bus.stat_branches, bus.stat_mispredicts, exp_stat_br(), exp_stat_mis());
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int k = 0; k < ENTRIES; k++) mdl_ctr[k] = 1;
    mdl_br  = 0;
    mdl_mis = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_predict();
    test_simultaneous();
    test_stall();
    test_nonbranch();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
